// File: rtl/pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwr_seq_ctrl
//
// Power-domain sequencer. Accepts one command at a time and walks the target
// domain(s) through the retention / isolation / power-switch / reset steps.
//
//   SHUTDOWN d   : SAVE (save[d] for SAVE_CYC) -> ISO (iso[d] set)
//                  -> SD (sd[d] set, dom_off[d] set, power_ack)
//   RESTORE d    : WAKE (sd cleared, wait for pwr_good, bounded by WAKE_TMO)
//   RESTORE_ALL  :   -> RESTORE (restore pulse) -> UNISO (iso cleared)
//                    -> RST (dom_reset for RST_CYC) -> DONE (dom_off cleared,
//                    power_ack). A wake timeout re-asserts sd and pulses err.
//   Illegal commands are answered with a single err pulse and no other effect.
//
// Ports
//   clock, reset_n        : clock, synchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_op, cmd_dom       : operation and target domain index
//   pwr_good[NDOM]        : per-domain power-good from the switch fabric
//   save/iso/sd/restore/dom_reset[NDOM] : per-domain controls
//                           (iso/sd polarity per ISO_LOW_MASK / SD_LOW_MASK)
//   dom_off[NDOM]         : domain powered-down status
//   power_ack, err        : one-cycle completion / error pulses
//   busy                  : sequence in progress (~cmd_ready)
//
// State actions happen on the clock edge that leaves a state, so every control
// output is a flop and each output becomes visible one cycle after the state
// that owns it is entered.
// -----------------------------------------------------------------------------
module pwr_seq_ctrl #(
    parameter int unsigned     NDOM         = 5,
    parameter int unsigned     SAVE_CYC     = 2,
    parameter int unsigned     WAKE_TMO     = 16,
    parameter int unsigned     RST_CYC      = 2,
    parameter logic [NDOM-1:0] ISO_LOW_MASK = '0,
    parameter logic [NDOM-1:0] SD_LOW_MASK  = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [$clog2(NDOM)-1:0] cmd_dom,
    input  logic [NDOM-1:0]         pwr_good,
    output logic [NDOM-1:0]         save,
    output logic [NDOM-1:0]         iso,
    output logic [NDOM-1:0]         sd,
    output logic [NDOM-1:0]         restore,
    output logic [NDOM-1:0]         dom_reset,
    output logic [NDOM-1:0]         dom_off,
    output logic                    power_ack,
    output logic                    err,
    output logic                    busy
);

    localparam logic [1:0] OP_NOP         = 2'd0;
    localparam logic [1:0] OP_SHUTDOWN    = 2'd1;
    localparam logic [1:0] OP_RESTORE     = 2'd2;
    localparam logic [1:0] OP_RESTORE_ALL = 2'd3;

    // One counter is shared by SAVE, WAKE and RST; size it for the longest.
    localparam int unsigned MAX_A  = (SAVE_CYC > RST_CYC) ? SAVE_CYC : RST_CYC;
    localparam int unsigned MAX_C  = (MAX_A > WAKE_TMO) ? MAX_A : WAKE_TMO;
    localparam int unsigned CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SAVE_LAST = CW'(SAVE_CYC - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_TMO - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SAVE,
        S_ISO,
        S_SD,
        S_WAKE,
        S_RESTORE,
        S_UNISO,
        S_RST,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [NDOM-1:0] tgt_q;
    logic [NDOM-1:0] save_q;
    logic [NDOM-1:0] iso_q;      // logical isolation (1 = isolated)
    logic [NDOM-1:0] sd_q;       // logical shutdown (1 = switch off)
    logic [NDOM-1:0] restore_q;
    logic [NDOM-1:0] drst_q;
    logic [NDOM-1:0] off_q;
    logic            ack_q;
    logic            err_q;

    // ---------------------------------------------------------------------
    // Command decode. sel_dom is one-hot of cmd_dom and all-zero when the
    // index is out of range, so an illegal index never addresses a domain.
    // ---------------------------------------------------------------------
    logic [NDOM-1:0] sel_dom;
    logic [NDOM-1:0] wake_set;
    logic            dom_ok;
    logic            sel_off;
    logic            start_sd;
    logic            start_wk;
    logic            reject;
    logic            all_good;

    always_comb begin
        sel_dom = '0;
        for (int i = 0; i < int'(NDOM); i++) begin
            if (int'(cmd_dom) == i) sel_dom[i] = 1'b1;
        end
    end

    assign dom_ok  = |sel_dom;
    assign sel_off = |(sel_dom & off_q);

    always_comb begin
        start_sd = 1'b0;
        start_wk = 1'b0;
        reject   = 1'b0;
        wake_set = '0;
        if (cmd_valid) begin
            unique case (cmd_op)
                OP_SHUTDOWN: begin
                    if (dom_ok && !sel_off) start_sd = 1'b1;
                    else                    reject   = 1'b1;
                end
                OP_RESTORE: begin
                    if (dom_ok && sel_off) begin
                        start_wk = 1'b1;
                        wake_set = sel_dom;
                    end else begin
                        reject = 1'b1;
                    end
                end
                OP_RESTORE_ALL: begin
                    if (|off_q) begin
                        start_wk = 1'b1;
                        wake_set = off_q;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: ;  // OP_NOP: accepted, nothing happens
            endcase
        end
    end

    // Domains outside the target set are masked to 1 so only targets matter.
    assign all_good = &(pwr_good | ~tgt_q);

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tgt_q     <= '0;
            save_q    <= '0;
            iso_q     <= '0;
            sd_q      <= '0;
            restore_q <= '0;
            drst_q    <= '0;
            off_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_sd) begin
                        tgt_q   <= sel_dom;
                        state_q <= S_SAVE;
                    end else if (start_wk) begin
                        tgt_q   <= wake_set;
                        sd_q    <= sd_q & ~wake_set;
                        state_q <= S_WAKE;
                    end else if (reject) begin
                        err_q <= 1'b1;
                    end
                end
                S_SAVE: begin
                    save_q <= tgt_q;
                    if (cnt_q == SAVE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_ISO;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_ISO: begin
                    save_q  <= '0;
                    iso_q   <= iso_q | tgt_q;
                    state_q <= S_SD;
                end
                S_SD: begin
                    sd_q    <= sd_q | tgt_q;
                    off_q   <= off_q | tgt_q;
                    ack_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_WAKE: begin
                    // power-good wins over a timeout on the same edge
                    if (all_good) begin
                        cnt_q   <= '0;
                        state_q <= S_RESTORE;
                    end else if (cnt_q == WAKE_LAST) begin
                        // switch back off; iso and dom_off were never released
                        sd_q    <= sd_q | tgt_q;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESTORE: begin
                    restore_q <= tgt_q;
                    state_q   <= S_UNISO;
                end
                S_UNISO: begin
                    restore_q <= '0;
                    iso_q     <= iso_q & ~tgt_q;
                    cnt_q     <= '0;
                    state_q   <= S_RST;
                end
                S_RST: begin
                    drst_q <= tgt_q;
                    if (cnt_q == RST_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    drst_q  <= '0;
                    off_q   <= off_q & ~tgt_q;
                    ack_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign save      = save_q;
    assign iso       = iso_q ^ ISO_LOW_MASK;
    assign sd        = sd_q ^ SD_LOW_MASK;
    assign restore   = restore_q;
    assign dom_reset = drst_q;
    assign dom_off   = off_q;
    assign power_ack = ack_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwr_seq_ctrl
//
// Two instances share all inputs: one with default parameters, one with
// iso/sd of domain 2 active-low. At each accepted command the reference model
// writes the expected per-cycle output timeline (derived from the sequencing
// rules) and pushes the expected ack/err event into a scoreboard queue. A
// monitor on the falling edge compares the outputs against the timeline and
// pops the queue whenever a pulse appears (or is due).
// -----------------------------------------------------------------------------
module tb_pwr_seq_ctrl;
    localparam int NDOM     = 5;
    localparam int SAVE_CYC = 2;
    localparam int WAKE_TMO = 16;
    localparam int RST_CYC  = 2;
    localparam int MAXC     = 16384;
    localparam logic [NDOM-1:0] ISO_M = 5'b00100;
    localparam logic [NDOM-1:0] SD_M  = 5'b00100;

    typedef struct { bit is_err; int acc; int lat; } exp_t;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic [1:0]      cmd_op = 2'd0;
    logic [2:0]      cmd_dom = 3'd0;
    logic [NDOM-1:0] pwr_good = '1;

    logic            cmd_ready, power_ack, err, busy;
    logic [NDOM-1:0] save, iso, sd, restore, dom_reset, dom_off;
    logic            m_cmd_ready, m_power_ack, m_err, m_busy;
    logic [NDOM-1:0] m_save, m_iso, m_sd, m_restore, m_dom_reset, m_dom_off;

    pwr_seq_ctrl dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dom(cmd_dom), .pwr_good(pwr_good),
        .save(save), .iso(iso), .sd(sd), .restore(restore), .dom_reset(dom_reset),
        .dom_off(dom_off), .power_ack(power_ack), .err(err), .busy(busy)
    );

    pwr_seq_ctrl #(.ISO_LOW_MASK(ISO_M), .SD_LOW_MASK(SD_M)) dut_m (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(m_cmd_ready),
        .cmd_op(cmd_op), .cmd_dom(cmd_dom), .pwr_good(pwr_good),
        .save(m_save), .iso(m_iso), .sd(m_sd), .restore(m_restore), .dom_reset(m_dom_reset),
        .dom_off(m_dom_off), .power_ack(m_power_ack), .err(m_err), .busy(m_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // expected timeline, indexed by cycle number
    logic [NDOM-1:0] e_save[MAXC], e_restore[MAXC], e_drst[MAXC];
    logic [NDOM-1:0] e_iso[MAXC], e_sd[MAXC], e_off[MAXC];
    bit              e_busy[MAXC];
    exp_t            sb[$];

    // abstract domain state after the last accepted command
    logic [NDOM-1:0] m_off = '0, m_iso_l = '0, m_sd_l = '0;
    int              dly[NDOM];
    bit              mon_en = 1'b0;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_lvl(input int c0, input logic [NDOM-1:0] i, input logic [NDOM-1:0] s,
                           input logic [NDOM-1:0] o);
        for (int c = c0; c < MAXC; c++) begin
            e_iso[c] = i; e_sd[c] = s; e_off[c] = o;
        end
    endtask

    task automatic mark_busy(input int acc, input int lat);
        for (int c = acc; c < acc + lat && c < MAXC; c++) e_busy[c] = 1'b1;
    endtask

    task automatic push(input bit is_err, input int acc, input int lat);
        exp_t e;
        e.is_err = is_err; e.acc = acc; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called at the falling edge: reset is sampled at the following rising edge.
    task automatic do_reset();
        int r;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        r = cyc;
        sb.delete();
        m_off = '0; m_iso_l = '0; m_sd_l = '0;
        set_lvl(r, '0, '0, '0);
        for (int c = r; c < MAXC; c++) begin
            e_save[c] = '0; e_restore[c] = '0; e_drst[c] = '0; e_busy[c] = 1'b0;
        end
        pwr_good = '1;
        mon_en   = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic do_shutdown(input int d, input int acc);
        logic [NDOM-1:0] t;
        t = '0; t[d] = 1'b1;
        for (int c = acc + 1; c <= acc + SAVE_CYC; c++) e_save[c] = t;
        set_lvl(acc + SAVE_CYC + 1, m_iso_l | t, m_sd_l, m_off);
        set_lvl(acc + SAVE_CYC + 2, m_iso_l | t, m_sd_l | t, m_off | t);
        mark_busy(acc, SAVE_CYC + 2);
        push(1'b0, acc, SAVE_CYC + 2);
        m_iso_l |= t; m_sd_l |= t; m_off |= t;
        pwr_good[d] = 1'b0;   // switch is off, so its power-good drops
    endtask

    task automatic do_restore(input logic [NDOM-1:0] t, input int acc);
        int j;
        bit ok;
        int last;
        j = 0;
        for (int k = 0; k < NDOM; k++) if (t[k] && dly[k] > j) j = dly[k];
        ok = (j <= WAKE_TMO);
        set_lvl(acc, m_iso_l, m_sd_l & ~t, m_off);
        if (ok) begin
            e_restore[acc + j + 1] = t;
            set_lvl(acc + j + 2, m_iso_l & ~t, m_sd_l & ~t, m_off);
            for (int c = acc + j + 3; c < acc + j + 3 + RST_CYC; c++) e_drst[c] = t;
            set_lvl(acc + j + 3 + RST_CYC, m_iso_l & ~t, m_sd_l & ~t, m_off & ~t);
            mark_busy(acc, j + 3 + RST_CYC);
            push(1'b0, acc, j + 3 + RST_CYC);
            m_iso_l &= ~t; m_sd_l &= ~t; m_off &= ~t;
        end else begin
            set_lvl(acc + WAKE_TMO, m_iso_l, m_sd_l, m_off);
            mark_busy(acc, WAKE_TMO);
            push(1'b1, acc, WAKE_TMO);
        end
        // raise each target's power-good so it is first sampled dly cycles after acceptance
        last = ok ? j : WAKE_TMO;
        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            for (int d = 0; d < NDOM; d++) if (t[d] && dly[d] == k) pwr_good[d] = 1'b1;
        end
        if (!ok) begin
            @(negedge clock);
            pwr_good &= ~t;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] dom);
        int n;
        int acc;
        logic [NDOM-1:0] t;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_dom = dom;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_wait_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        acc = cyc;
        case (op)
            2'd1: if (dom >= NDOM || m_off[dom]) push(1'b1, acc, 0);
                  else do_shutdown(int'(dom), acc);
            2'd2: if (dom >= NDOM || !m_off[dom]) push(1'b1, acc, 0);
                  else begin
                      t = '0; t[dom] = 1'b1;
                      do_restore(t, acc);
                  end
            2'd3: if (m_off == '0) push(1'b1, acc, 0);
                  else do_restore(m_off, acc);
            default: ;
        endcase
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    always @(negedge clock) begin
        exp_t e;
        if (mon_en && cyc < MAXC) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!e_busy[cyc]));
            chk("busy", 32'(busy), 32'(e_busy[cyc]));
            chk("save", 32'(save), 32'(e_save[cyc]));
            chk("restore", 32'(restore), 32'(e_restore[cyc]));
            chk("dom_reset", 32'(dom_reset), 32'(e_drst[cyc]));
            chk("iso", 32'(iso), 32'(e_iso[cyc]));
            chk("sd", 32'(sd), 32'(e_sd[cyc]));
            chk("dom_off", 32'(dom_off), 32'(e_off[cyc]));
            chk("m_iso_port", 32'(m_iso), 32'(e_iso[cyc] ^ ISO_M));
            chk("m_sd_port", 32'(m_sd), 32'(e_sd[cyc] ^ SD_M));
            chk("m_dom_off", 32'(m_dom_off), 32'(e_off[cyc]));
            chk("m_ctrl", 32'({m_cmd_ready, m_save, m_restore, m_dom_reset}),
                32'({!e_busy[cyc], e_save[cyc], e_restore[cyc], e_drst[cyc]}));
            if (power_ack || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'({power_ack, err}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_err", 32'(err), 32'(e.is_err));
                    chk("pulse_ack", 32'(power_ack), 32'(!e.is_err));
                    chk("pulse_latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("m_pulse", 32'({m_power_ack, m_err}), 32'({!e.is_err, e.is_err}));
                end
            end else if (sb.size() > 0 && cyc >= sb[0].acc + sb[0].lat) begin
                e = sb.pop_front();
                chk("pulse_due", 32'({power_ack, err}), 32'({!e.is_err, e.is_err}));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        for (int c = 0; c < MAXC; c++) begin
            e_save[c] = '0; e_restore[c] = '0; e_drst[c] = '0;
            e_iso[c] = '0; e_sd[c] = '0; e_off[c] = '0; e_busy[c] = 1'b0;
        end
        for (int d = 0; d < NDOM; d++) dly[d] = 4;
        @(negedge clock);
        do_reset();

        // shutdown dom 2, then restore it with power-good 3 cycles later
        issue(2'd1, 3'd2);
        dly[2] = 3;
        issue(2'd2, 3'd2);

        // doms 1 and 3 off; restore-all where dom 1 never powers up
        issue(2'd1, 3'd1);
        issue(2'd1, 3'd3);
        dly[1] = 255; dly[3] = 2;
        issue(2'd3, 3'd0);

        // illegal commands and NOPs
        issue(2'd1, 3'd1);
        issue(2'd2, 3'd0);
        issue(2'd1, 3'd7);
        issue(2'd2, 3'd7);
        issue(2'd0, 3'd7);
        issue(2'd0, 3'd0);

        // bring everything back, then abort a restore while in RST
        for (int d = 0; d < NDOM; d++) dly[d] = 4;
        issue(2'd3, 3'd0);
        issue(2'd3, 3'd0);
        dly[2] = 3;
        issue(2'd1, 3'd2);
        issue(2'd2, 3'd2);
        repeat (4) @(negedge clock);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 300 && cyc < MAXC - 300; n++) begin
            logic [1:0] op;
            logic [2:0] dm;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dm = 3'($urandom_range(5, 7));
            else                           dm = 3'($urandom_range(0, 4));
            for (int d = 0; d < NDOM; d++)
                dly[d] = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(1, 20));
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clock);
                do_reset();
            end
            issue(op, dm);
        end

        repeat (40) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
